memory_access: RTL and testbench

Pipeline memory (MEM) stage of the LEGv8 core, fed by the execute stage's ALU result, store data, branch target and zero flag. It registers the EX/MEM boundary and resolves CBZ-style branches. It runs loads and stores over a req/ack data-memory bus and stalls upstream while an access is outstanding. It delivers one completed instruction per cycle (at most) to writeback.

---
 rtl/memory_access_pkg.sv | 12 +
 rtl/mux2.sv | 16 +
 rtl/memory_access.sv | 164 ++++++++++++++++
 tb/tb_memory_access.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding and
// the register-index width used for destination register fields.
package memory_access_pkg;

    typedef enum logic {
        MA_IDLE,
        MA_ACCESS
    } mem_state_t;

    localparam int REG_IDX_W = 5;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer: y = s ? d1 : d0.
module mux2 #(
    parameter int N = 64
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic         s,
    output logic [N-1:0] y
);

    // Pure select, no state.
    always_comb begin
        y = s ? d1 : d0;
    end

endmodule

// File: rtl/memory_access.sv
// LEGv8 MEM stage: registers the EX/MEM boundary, resolves CBZ-style
// branches, runs loads/stores over a req/ack data-memory bus and stalls
// upstream while an access is outstanding.
//
// Handshake: an instruction is accepted on a rising edge where valid_E=1
// and stall_M=0; upstream holds its outputs while stall_M=1. The memory bus
// keeps dm_req/dm_we/dm_addr/dm_wdata stable until the first cycle with
// dm_ack=1, which completes the request in that same cycle.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int N = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_E,
    input  logic [REG_IDX_W-1:0] rd_E,
    input  logic                 regWrite_E,
    input  logic                 memRead_E,
    input  logic                 memWrite_E,
    input  logic                 memtoReg_E,
    input  logic                 branch_E,
    input  logic                 zero_E,
    input  logic [N-1:0]         PCBranch_E,
    input  logic [N-1:0]         aluResult_E,
    input  logic [N-1:0]         writeData_E,
    output logic                 stall_M,
    output logic                 PCSrc_M,
    output logic [N-1:0]         PCBranch_M,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [N-1:0]         dm_addr,
    output logic [N-1:0]         dm_wdata,
    input  logic                 dm_ack,
    input  logic [N-1:0]         dm_rdata,
    output logic                 wb_valid,
    output logic                 wb_regWrite,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [N-1:0]         wb_result,
    output mem_state_t           dbg_state
);

    mem_state_t           state_q, state_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic                 regwrite_q, regwrite_d;
    logic                 memtoreg_q, memtoreg_d;
    logic                 we_q, we_d;
    logic [N-1:0]         alu_q, alu_d;
    logic [N-1:0]         wdata_q, wdata_d;
    logic                 wb_valid_q, wb_valid_d;
    logic                 wb_regwrite_q, wb_regwrite_d;
    logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
    logic [N-1:0]         wb_result_q, wb_result_d;
    logic                 pcsrc_q, pcsrc_d;
    logic [N-1:0]         pcbranch_q, pcbranch_d;
    logic [N-1:0]         mem_result;
    logic                 in_access;

    // Load result vs. address-style result for a completing memory op.
    mux2 #(.N(N)) u_result_mux (
        .d0 (alu_q),
        .d1 (dm_rdata),
        .s  (memtoreg_q),
        .y  (mem_result)
    );

    assign in_access   = (state_q == MA_ACCESS);
    assign stall_M     = in_access;
    assign dm_req      = in_access;
    assign dm_we       = in_access & we_q;
    assign dm_addr     = in_access ? alu_q   : '0;
    assign dm_wdata    = in_access ? wdata_q : '0;
    assign PCSrc_M     = pcsrc_q;
    assign PCBranch_M  = pcbranch_q;
    assign wb_valid    = wb_valid_q;
    assign wb_regWrite = wb_regwrite_q;
    assign wb_rd       = wb_rd_q;
    assign wb_result   = wb_result_q;
    assign dbg_state   = state_q;

    // Next-state, capture and writeback logic; wb/branch strobes default to one-cycle pulses.
    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        regwrite_d    = regwrite_q;
        memtoreg_d    = memtoreg_q;
        we_d          = we_q;
        alu_d         = alu_q;
        wdata_d       = wdata_q;
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_rd_d       = '0;
        wb_result_d   = '0;
        pcsrc_d       = 1'b0;
        pcbranch_d    = '0;
        case (state_q)
            MA_IDLE: begin
                if (valid_E) begin
                    if (memRead_E | memWrite_E) begin
                        // Both read and write set behaves as a store via we_d.
                        state_d    = MA_ACCESS;
                        rd_d       = rd_E;
                        regwrite_d = regWrite_E;
                        memtoreg_d = memtoReg_E;
                        we_d       = memWrite_E;
                        alu_d      = aluResult_E;
                        wdata_d    = writeData_E;
                    end else begin
                        wb_valid_d    = 1'b1;
                        wb_regwrite_d = regWrite_E;
                        wb_rd_d       = rd_E;
                        wb_result_d   = aluResult_E;
                        pcsrc_d       = branch_E & zero_E;
                        pcbranch_d    = PCBranch_E;
                    end
                end
            end
            MA_ACCESS: begin
                if (dm_ack) begin
                    state_d       = MA_IDLE;
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = regwrite_q;
                    wb_rd_d       = rd_q;
                    wb_result_d   = mem_result;
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    // State and pipeline registers; async reset discards any pending access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= MA_IDLE;
            rd_q          <= '0;
            regwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            we_q          <= 1'b0;
            alu_q         <= '0;
            wdata_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_result_q   <= '0;
            pcsrc_q       <= 1'b0;
            pcbranch_q    <= '0;
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            regwrite_q    <= regwrite_d;
            memtoreg_q    <= memtoreg_d;
            we_q          <= we_d;
            alu_q         <= alu_d;
            wdata_q       <= wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_rd_q       <= wb_rd_d;
            wb_result_q   <= wb_result_d;
            pcsrc_q       <= pcsrc_d;
            pcbranch_q    <= pcbranch_d;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: ALU writeback, CBZ resolution, waited
// load with held follower, zero-wait store, read+write as store, and
// reset during an access.
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_E;
    logic [4:0]   rd_E;
    logic         regWrite_E, memRead_E, memWrite_E, memtoReg_E, branch_E, zero_E;
    logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
    logic         stall_M, PCSrc_M;
    logic [N-1:0] PCBranch_M;
    logic         dm_req, dm_we;
    logic [N-1:0] dm_addr, dm_wdata;
    logic         dm_ack;
    logic [N-1:0] dm_rdata;
    logic         wb_valid, wb_regWrite;
    logic [4:0]   wb_rd;
    logic [N-1:0] wb_result;
    mem_state_t   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Clock
    always #5 clk = ~clk;

    memory_access #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_E     (valid_E),
        .rd_E        (rd_E),
        .regWrite_E  (regWrite_E),
        .memRead_E   (memRead_E),
        .memWrite_E  (memWrite_E),
        .memtoReg_E  (memtoReg_E),
        .branch_E    (branch_E),
        .zero_E      (zero_E),
        .PCBranch_E  (PCBranch_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .stall_M     (stall_M),
        .PCSrc_M     (PCSrc_M),
        .PCBranch_M  (PCBranch_M),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .wb_valid    (wb_valid),
        .wb_regWrite (wb_regWrite),
        .wb_rd       (wb_rd),
        .wb_result   (wb_result),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_E     = 1'b0;
        rd_E        = '0;
        regWrite_E  = 1'b0;
        memRead_E   = 1'b0;
        memWrite_E  = 1'b0;
        memtoReg_E  = 1'b0;
        branch_E    = 1'b0;
        zero_E      = 1'b0;
        PCBranch_E  = '0;
        aluResult_E = '0;
        writeData_E = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"},    64'(stall_M),     64'd0);
        chk({tag, ".pcsrc"},    64'(PCSrc_M),     64'd0);
        chk({tag, ".pcbranch"}, PCBranch_M,       64'd0);
        chk({tag, ".dm_req"},   64'(dm_req),      64'd0);
        chk({tag, ".dm_we"},    64'(dm_we),       64'd0);
        chk({tag, ".dm_addr"},  dm_addr,          64'd0);
        chk({tag, ".dm_wdata"}, dm_wdata,         64'd0);
        chk({tag, ".wb_valid"}, 64'(wb_valid),    64'd0);
        chk({tag, ".wb_regw"},  64'(wb_regWrite), 64'd0);
        chk({tag, ".wb_rd"},    64'(wb_rd),       64'd0);
        chk({tag, ".wb_res"},   wb_result,        64'd0);
    endtask

    initial begin
        // Reset with a valid instruction offered: nothing may be accepted.
        reset    = 1'b0;
        dm_ack   = 1'b0;
        dm_rdata = '0;
        idle_inputs();
        valid_E     = 1'b1;
        aluResult_E = 64'h11;
        regWrite_E  = 1'b1;
        rd_E        = 5'd1;
        step();
        step();
        chk_all_zero("reset");
        chk("reset.state", 64'(dbg_state), 64'(MA_IDLE));
        idle_inputs();
        reset = 1'b1;
        step();
        chk("post_reset.wb_valid", 64'(wb_valid), 64'd0);

        // ALU op: result one cycle after accept.
        valid_E     = 1'b1;
        aluResult_E = 64'h2A;
        rd_E        = 5'd3;
        regWrite_E  = 1'b1;
        chk("alu.stall_pre", 64'(stall_M), 64'd0);
        step();
        idle_inputs();
        chk("alu.wb_valid", 64'(wb_valid),    64'd1);
        chk("alu.wb_rd",    64'(wb_rd),       64'd3);
        chk("alu.wb_res",   wb_result,        64'h2A);
        chk("alu.wb_regw",  64'(wb_regWrite), 64'd1);
        chk("alu.stall",    64'(stall_M),     64'd0);
        chk("alu.pcsrc",    64'(PCSrc_M),     64'd0);
        step();
        chk("alu.wb_valid_drop", 64'(wb_valid), 64'd0);

        // CBZ taken then, back-to-back, CBZ not taken.
        valid_E    = 1'b1;
        branch_E   = 1'b1;
        zero_E     = 1'b1;
        PCBranch_E = 64'h100;
        step();
        zero_E     = 1'b0;
        PCBranch_E = 64'h200;
        chk("cbz_t.pcsrc",    64'(PCSrc_M),  64'd1);
        chk("cbz_t.pcbranch", PCBranch_M,    64'h100);
        chk("cbz_t.wb_valid", 64'(wb_valid), 64'd1);
        step();
        idle_inputs();
        chk("cbz_nt.pcsrc",    64'(PCSrc_M),  64'd0);
        chk("cbz_nt.pcbranch", PCBranch_M,    64'h200);
        chk("cbz_nt.wb_valid", 64'(wb_valid), 64'd1);
        step();
        chk("cbz.pcsrc_drop",    64'(PCSrc_M),  64'd0);
        chk("cbz.pcbranch_drop", PCBranch_M,    64'd0);
        chk("cbz.wb_valid_drop", 64'(wb_valid), 64'd0);

        // Load at 0x40, ack three cycles late; an ALU op waits behind it.
        valid_E     = 1'b1;
        memRead_E   = 1'b1;
        memtoReg_E  = 1'b1;
        regWrite_E  = 1'b1;
        rd_E        = 5'd7;
        aluResult_E = 64'h40;
        writeData_E = 64'h99;
        step();
        idle_inputs();
        valid_E     = 1'b1;
        rd_E        = 5'd9;
        regWrite_E  = 1'b1;
        aluResult_E = 64'h77;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ld.dm_req%0d", i),   64'(dm_req),   64'd1);
            chk($sformatf("ld.dm_addr%0d", i),  dm_addr,       64'h40);
            chk($sformatf("ld.dm_we%0d", i),    64'(dm_we),    64'd0);
            chk($sformatf("ld.stall%0d", i),    64'(stall_M),  64'd1);
            chk($sformatf("ld.wb_valid%0d", i), 64'(wb_valid), 64'd0);
            dm_ack   = (i == 3);
            dm_rdata = (i == 3) ? 64'hDEAD : 64'h1234;
            step();
        end
        dm_ack   = 1'b0;
        dm_rdata = '0;
        chk("ld.wb_valid", 64'(wb_valid),    64'd1);
        chk("ld.wb_res",   wb_result,        64'hDEAD);
        chk("ld.wb_rd",    64'(wb_rd),       64'd7);
        chk("ld.wb_regw",  64'(wb_regWrite), 64'd1);
        chk("ld.stall",    64'(stall_M),     64'd0);
        chk("ld.dm_req",   64'(dm_req),      64'd0);
        chk("ld.dm_addr",  dm_addr,          64'd0);
        step();
        idle_inputs();
        chk("follow.wb_valid", 64'(wb_valid), 64'd1);
        chk("follow.wb_rd",    64'(wb_rd),    64'd9);
        chk("follow.wb_res",   wb_result,     64'h77);
        step();

        // Store 0x55 to 0x80, zero-wait ack.
        valid_E     = 1'b1;
        memWrite_E  = 1'b1;
        aluResult_E = 64'h80;
        writeData_E = 64'h55;
        step();
        idle_inputs();
        chk("st.dm_req",   64'(dm_req),   64'd1);
        chk("st.dm_we",    64'(dm_we),    64'd1);
        chk("st.dm_addr",  dm_addr,       64'h80);
        chk("st.dm_wdata", dm_wdata,      64'h55);
        chk("st.stall",    64'(stall_M),  64'd1);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        chk("st.wb_valid", 64'(wb_valid),    64'd1);
        chk("st.wb_regw",  64'(wb_regWrite), 64'd0);
        chk("st.wb_res",   wb_result,        64'h80);
        chk("st.dm_req0",  64'(dm_req),      64'd0);
        chk("st.dm_we0",   64'(dm_we),       64'd0);
        chk("st.wdata0",   dm_wdata,         64'd0);
        step();
        chk("st.wb_valid_drop", 64'(wb_valid), 64'd0);

        // Read and write both set: behaves as a store.
        valid_E     = 1'b1;
        memRead_E   = 1'b1;
        memWrite_E  = 1'b1;
        aluResult_E = 64'h10;
        writeData_E = 64'h20;
        step();
        idle_inputs();
        chk("rw.dm_we",    64'(dm_we), 64'd1);
        chk("rw.dm_wdata", dm_wdata,   64'h20);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        chk("rw.wb_valid", 64'(wb_valid), 64'd1);
        step();

        // Reset during an access, then a stray ack while idle.
        valid_E     = 1'b1;
        memRead_E   = 1'b1;
        memtoReg_E  = 1'b1;
        regWrite_E  = 1'b1;
        rd_E        = 5'd5;
        aluResult_E = 64'h40;
        step();
        idle_inputs();
        chk("rst_acc.dm_req_pre", 64'(dm_req), 64'd1);
        reset = 1'b0;
        #1;
        chk_all_zero("rst_acc");
        step();
        reset = 1'b1;
        dm_ack   = 1'b1;
        dm_rdata = 64'hBEEF;
        step();
        chk("stray.wb_valid", 64'(wb_valid), 64'd0);
        chk("stray.stall",    64'(stall_M),  64'd0);
        chk("stray.dm_req",   64'(dm_req),   64'd0);
        dm_ack   = 1'b0;
        dm_rdata = '0;
        step();
        chk("stray.wb_valid2", 64'(wb_valid), 64'd0);
        chk("stray.state", 64'(dbg_state), 64'(MA_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
